// File: rtl/sync_fifo_structural.sv
// Single-clock FIFO built from a register array and two wrap-bit pointers.
// Flags are decoded combinationally from the pointers; read data is registered.
module sync_fifo_structural #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             W_en,
    input  logic             R_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Same address with opposite wrap bits means the writer is a full lap ahead.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign wr_acc = W_en && !full;
    assign rd_acc = R_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            data_out <= '0;
        end else if (rd_acc) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            data_out <= mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_sync_fifo_structural.sv
// Bench for sync_fifo_structural: directed scenarios plus random traffic,
// compared against a queue-based occupancy/ordering model.
module tb_sync_fifo_structural;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             W_en = 1'b0;
    logic             R_en = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    int checks = 0;
    int failures = 0;
    string phase = "init";

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] dout_m = '0;

    sync_fifo_structural #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .W_en(W_en),
        .R_en(R_en),
        .data_in(data_in),
        .data_out(data_out),
        .full(full),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("data_out", 32'(data_out), 32'(dout_m));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("empty", 32'(empty), 32'(q.size() == 0));
    endtask

    // One clock edge; flags used for qualification are those before the edge.
    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        W_en = w;
        R_en = r;
        data_in = d;
        @(posedge clk);
        rd_ok = r && (q.size() != 0);
        wr_ok = w && (q.size() != DEPTH);
        if (rd_ok) dout_m = q.pop_front();
        if (wr_ok) q.push_back(d);
        #1;
        check_outputs();
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        dout_m = '0;
        check_outputs();
        for (int i = 0; i < 2; i++) begin
            W_en = 1'($urandom);
            R_en = 1'($urandom);
            data_in = WIDTH'($urandom);
            @(posedge clk);
            #1;
            check_outputs();
        end
        @(negedge clk);
        reset = 1'b1;
        W_en = 1'b0;
        R_en = 1'b0;
    endtask

    initial begin
        // Reset with no clock edge yet
        phase = "reset";
        #2;
        reset = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;

        phase = "fill";
        step(1'b1, 1'b0, 8'd0);
        for (int i = 2; i <= 10; i++) step(1'b1, 1'b0, WIDTH'(i));
        check("fill_count", 32'(q.size()), 32'(DEPTH));

        phase = "drain";
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 8'h00);
        check("drain_last", 32'(data_out), 32'h8);

        phase = "wrap";
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(8'h40 + i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, WIDTH'(8'h10 + i));
        check("wrap_full", 32'(full), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("wrap_order", 32'(data_out), 32'(8'h10 + i));
        end

        phase = "simul_full";
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, WIDTH'(8'h60 + i));
        step(1'b1, 1'b1, 8'hEE);
        check("simul_full_read", 32'(data_out), 32'h60);
        check("simul_full_flag", 32'(full), 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);

        phase = "simul_empty";
        step(1'b1, 1'b1, 8'hAA);
        check("simul_empty_dout", 32'(data_out), 32'h67);
        check("simul_empty_flag", 32'(empty), 32'h0);
        step(1'b0, 1'b1, 8'h00);

        phase = "mid_reset";
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, WIDTH'(8'h70 + i));
        reset_pulse();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

        phase = "random";
        for (int blk = 0; blk < 6; blk++) begin
            int wp = (blk % 3 == 0) ? 80 : (blk % 3 == 1) ? 30 : 55;
            for (int i = 0; i < 80; i++) begin
                step(1'($urandom_range(99) < wp), 1'($urandom_range(99) < (100 - wp)),
                     WIDTH'($urandom));
            end
            if (blk == 3) reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_structural.md
SYNC_FIFO_STRUCTURAL -- requirements
Module: sync_fifo_structural

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of storage entries; it SHALL be a power of two and at least 2.
REQ-003 Clocking and reset SHALL be one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be the asynchronous active-low reset; 0 means in reset.
REQ-006 Port W_en, input, 1 bit, SHALL be the write request, sampled on the rising clk edge.
REQ-007 Port R_en, input, 1 bit, SHALL be the read request, sampled on the rising clk edge.
REQ-008 Port data_in, input, WIDTH bits, SHALL be the write data, captured when a write is accepted.
REQ-009 Port data_out, output, WIDTH bits, SHALL be the registered read data.
REQ-010 Port full, output, 1 bit, SHALL be high when DEPTH entries are stored.
REQ-011 Port empty, output, 1 bit, SHALL be high when 0 entries are stored.

Function
REQ-012 Storage SHALL be a DEPTH x WIDTH register array with write and read pointers of log2(DEPTH)+1 bits; the extra MSB is the wrap bit.
REQ-013 empty SHALL equal (wr_ptr == rd_ptr); full SHALL equal (address bits equal AND wrap bits differ); both flags SHALL be combinational from the pointer registers.
REQ-014 A write SHALL be accepted when W_en=1 and full=0: data_in is stored at mem[wr_ptr address] and wr_ptr increments by 1 in the same edge.
REQ-015 When W_en=1 and full=1, the write SHALL be dropped: memory and wr_ptr are unchanged and no error is flagged.
REQ-016 A read SHALL be accepted when R_en=1 and empty=0: data_out loads mem[rd_ptr address] on that edge (1-cycle latency) and rd_ptr increments by 1.
REQ-017 When R_en=1 and empty=1, the read SHALL be ignored: rd_ptr is unchanged and data_out holds its previous value.
REQ-018 data_out SHALL hold its last read value in every cycle without an accepted read.
REQ-019 When R_en=1 and W_en=1 on the same edge, each operation SHALL be qualified by the flags as they were before that edge.
REQ-020 A simultaneous read and write while full SHALL perform the read only and drop the write; the FIFO ends with DEPTH-1 entries.
REQ-021 A simultaneous read and write while empty SHALL perform the write only; there is no fall-through, and data_out is unchanged.
REQ-022 A simultaneous read and write in any other state SHALL perform both operations; occupancy and flags stay unchanged.
REQ-023 Pointers SHALL wrap modulo 2*DEPTH; addressing SHALL wrap modulo DEPTH, so FIFO order is preserved across wrap-around.
REQ-024 Occupancy SHALL never exceed DEPTH and never go below 0.

Reset
REQ-025 While reset=0, wr_ptr, rd_ptr and data_out SHALL be forced to 0 immediately, independent of clk.
REQ-026 Under reset, empty SHALL be 1 and full SHALL be 0.
REQ-027 Memory contents need not be cleared.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries, and W_en/R_en SHALL be ignored while reset=0.
REQ-029 On the first rising edge after reset returns to 1, normal operation SHALL begin.

Verification
REQ-030 Reset check: assert reset=0 with no clock edge -> data_out=0, empty=1, full=0.
REQ-031 Write until full: after reset, W_en=1 for 10 edges with data_in=0,2,3,4,5,6,7,8,9,10 -> full=1 after the 8th edge, empty=0, and 9 and 10 are dropped.
REQ-032 Read until empty: then R_en=1 for 18 edges -> data_out=0,2,3,4,5,6,7,8 on edges 1-8, empty=1 after the 8th edge, and data_out holds 8 on edges 9-18.
REQ-033 Wrap-around: write 5 words, read 5, then write 8 words 0x10-0x17 -> full=1, and read-back order is 0x10..0x17.
REQ-034 Simultaneous access: with the FIFO full, apply R_en=W_en=1 -> one word is read, the write is dropped, full=0; with the FIFO empty, apply R_en=W_en=1 with data_in=0xAA -> empty=0 and data_out is unchanged.
REQ-035 Mid-operation reset: write 3 words, then pulse reset=0 between edges -> empty=1 and data_out=0 immediately, and subsequent reads return nothing new.
